ecpri_rma_scheduler: RTL and testbench
======================================

// Module: ecpri_rma_scheduler
// PURPOSE
//   Sequences eCPRI remote-memory-access (RMA) requests decoded by the eCPRI rx parser.
//   Queues request headers and runs each one in order against a single-port byte memory.
//   Streams read payload to the tx framer, then raises a response request to the tx framer.
//   Sits between ecpri rx parser, the RMA memory and the ecpri tx framer; sole owner of the memory port.
// PARAMETERS
//   ADDR_W  8  memory byte-address width; addresses wrap modulo 2**ADDR_W
//   LEN_W   8  payload length width in bytes
//   DEPTH   4  request-header queue depth, power of 2, >=2
// PORTS
//   clk            in   1       single clock, all logic on posedge
//   reset          in   1       asynchronous, active-high
//   req_valid      in   1       rx parser offers a request header
//   req_ready      out  1       queue can accept; = (count < DEPTH)
//   req_rw         in   1       1 = write (eCPRI 0x10), 0 = read (eCPRI 0x00)
//   req_addr       in   ADDR_W  start byte address
//   req_len        in   LEN_W   payload bytes; 0 allowed
//   req_seq        in   8       sequence id, echoed in the response
//   wr_data_valid  in   1       write payload byte from rx, in request order
//   wr_data        in   8       write payload byte
//   wr_data_ready  out  1       scheduler consumes a write byte
//   mem_en         out  1       memory access strobe
//   mem_we         out  1       1 = write
//   mem_addr       out  ADDR_W  memory address
//   mem_wdata      out  8       memory write data
//   mem_rdata      in   8       read data, valid the cycle after a read strobe
//   rd_data_valid  out  1       read payload byte to tx framer
//   rd_data        out  8       read payload byte
//   rd_data_ready  in   1       tx framer accepts the byte
//   resp_valid     out  1       response request to tx framer
//   resp_ready     in   1       tx framer accepts the response
//   resp_rw / resp_seq / resp_len  out  1/8/LEN_W  response fields of the completed request
//   busy           out  1       state != IDLE or queue non-empty
// BEHAVIOUR
//   Reset: all outputs 0; queue is emptied; FSM goes to IDLE; in-flight request is dropped, no response.
//     Once reset is low, req_ready = 1.
//   Queue:
//     - Push on req_valid & req_ready; FIFO order is preserved.
//     - req_ready is based only on registered count: a full queue does not accept a push even when a pop happens in the same cycle.
//     - Push and pop in the same cycle leave count unchanged.
//   FSM states: IDLE, WRITE, READ_ISSUE, READ_CAP, READ_OUT, RESP.
//   IDLE:
//     - If the queue is non-empty, pop into cur_rw/cur_addr/cur_cnt/cur_seq/cur_len.
//     - If len == 0 -> RESP; else if rw -> WRITE; else -> READ_ISSUE.
//     - A request accepted at edge N leaves IDLE no earlier than edge N+1.
//   WRITE:
//     - wr_data_ready = 1; mem_en = mem_we = wr_data_valid.
//     - mem_addr = cur_addr; mem_wdata = wr_data.
//     - On each handshake: cur_addr += 1 (wraps), cur_cnt -= 1.
//     - When the last byte is taken -> RESP.
//   READ_ISSUE: mem_en = 1, mem_we = 0, mem_addr = cur_addr -> READ_CAP.
//   READ_CAP: capture mem_rdata into rd_data -> READ_OUT.
//   READ_OUT:
//     - rd_data_valid = 1; rd_data holds stable until rd_data_ready.
//     - On handshake: cur_addr += 1, cur_cnt -= 1.
//     - Go to RESP if cur_cnt was 1, else READ_ISSUE.
//     - Throughput is at most 1 byte per 3 cycles.
//   RESP:
//     - resp_valid = 1 with fields held stable until resp_ready; then -> IDLE.
//     - The next request is not started in the same cycle.
//   Outside their states, mem_en, mem_we, wr_data_ready, rd_data_valid and resp_valid are 0.
//     mem_addr and mem_wdata are don't-care when mem_en = 0.
//   resp_len is the original req_len; cur_cnt never underflows.
// TESTING
//   1 Write seq=0x05, addr=0x10, len=4, data AA BB CC DD -> mem writes 0x10..0x13 = AA BB CC DD;
//     then resp_valid with rw=1, seq=05, len=4.
//   2 Memory preloaded 0x20..0x22 = 11 22 33; read len=3 with rd_data_ready toggling
//     -> 11, 22, 33 delivered in order, held while stalled; then resp rw=0, len=3.
//   3 rd_data_ready=0, queue empty; offer 6 requests back-to-back
//     -> 5 accepted (1 in service + 4 queued); 6th sees req_ready=0; all complete in submission order.
//   4 Write addr=0xFE, len=3 -> mem writes to 0xFE, 0xFF, 0x00.
//   5 Read len=0, seq=0x7F -> no mem_en; resp_valid one cycle after leaving IDLE, with len=0.
//   6 reset pulse after 2 of 4 write bytes with 2 requests queued
//     -> all outputs 0, busy=0, no resp; a new write afterwards completes normally.

Source files
------------

// File: rtl/ecpri_rma_scheduler.sv
// eCPRI RMA request scheduler: queues rx-parsed request headers and runs them in order
// against a single-port byte memory, streaming read payload and raising responses to tx.
module ecpri_rma_scheduler #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned LEN_W  = 8,
   parameter int unsigned DEPTH  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_rw,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [LEN_W-1:0]  req_len,
   input  logic [7:0]        req_seq,
   input  logic              wr_data_valid,
   input  logic [7:0]        wr_data,
   output logic              wr_data_ready,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   input  logic [7:0]        mem_rdata,
   output logic              rd_data_valid,
   output logic [7:0]        rd_data,
   input  logic              rd_data_ready,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic              resp_rw,
   output logic [7:0]        resp_seq,
   output logic [LEN_W-1:0]  resp_len,
   output logic              busy
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef struct packed {
      logic              rw;
      logic [ADDR_W-1:0] addr;
      logic [LEN_W-1:0]  len;
      logic [7:0]        seq;
   } hdr_t;

   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      READ_ISSUE,
      READ_CAP,
      READ_OUT,
      RESP
   } state_t;

   hdr_t              q_mem [DEPTH];
   hdr_t              head;
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count;
   logic              push;
   logic              pop;

   state_t            state;
   logic              cur_rw;
   logic [ADDR_W-1:0] cur_addr;
   logic [LEN_W-1:0]  cur_cnt;
   logic [LEN_W-1:0]  cur_len;
   logic [7:0]        cur_seq;

   // Acceptance looks only at the registered count, so a full queue never takes a push.
   assign req_ready = ~reset & (count < CNT_W'(DEPTH));
   assign push      = req_valid & req_ready;
   assign pop       = (state == IDLE) && (count != '0);
   assign head      = q_mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push) q_mem[wr_ptr] <= {req_rw, req_addr, req_len, req_seq};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Request sequencer; cur_cnt only decrements while it is non-zero in WRITE/READ_OUT.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         cur_rw   <= 1'b0;
         cur_addr <= '0;
         cur_cnt  <= '0;
         cur_len  <= '0;
         cur_seq  <= '0;
         rd_data  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pop) begin
                  cur_rw   <= head.rw;
                  cur_addr <= head.addr;
                  cur_cnt  <= head.len;
                  cur_len  <= head.len;
                  cur_seq  <= head.seq;
                  if (head.len == '0)  state <= RESP;
                  else if (head.rw)    state <= WRITE;
                  else                 state <= READ_ISSUE;
               end
            end
            WRITE: begin
               if (wr_data_valid) begin
                  cur_addr <= cur_addr + ADDR_W'(1);
                  cur_cnt  <= cur_cnt - LEN_W'(1);
                  if (cur_cnt == LEN_W'(1)) state <= RESP;
               end
            end
            READ_ISSUE: state <= READ_CAP;
            READ_CAP: begin
               rd_data <= mem_rdata;
               state   <= READ_OUT;
            end
            READ_OUT: begin
               if (rd_data_ready) begin
                  cur_addr <= cur_addr + ADDR_W'(1);
                  cur_cnt  <= cur_cnt - LEN_W'(1);
                  state    <= (cur_cnt == LEN_W'(1)) ? RESP : READ_ISSUE;
               end
            end
            RESP: begin
               if (resp_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign wr_data_ready = (state == WRITE);
   assign mem_we        = (state == WRITE) & wr_data_valid;
   assign mem_en        = mem_we | (state == READ_ISSUE);
   assign mem_addr      = cur_addr;
   assign mem_wdata     = (state == WRITE) ? wr_data : 8'h00;
   assign rd_data_valid = (state == READ_OUT);
   assign resp_valid    = (state == RESP);
   assign resp_rw       = cur_rw;
   assign resp_seq      = cur_seq;
   assign resp_len      = cur_len;
   assign busy          = (state != IDLE) || (count != '0);

endmodule

// File: tb/tb_ecpri_rma_scheduler.sv
// Randomised bench for ecpri_rma_scheduler: attached byte RAM plus an in-order
// request model that predicts memory effects, read payload and responses.
module tb_ecpri_rma_scheduler;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       req_valid = 1'b0, req_ready, req_rw = 1'b0;
   logic [7:0] req_addr = '0, req_len = '0, req_seq = '0;
   logic       wr_data_valid = 1'b0, wr_data_ready;
   logic [7:0] wr_data = '0;
   logic       mem_en, mem_we;
   logic [7:0] mem_addr, mem_wdata;
   logic [7:0] mem_rdata = '0;
   logic       rd_data_valid, rd_data_ready = 1'b0;
   logic [7:0] rd_data;
   logic       resp_valid, resp_ready = 1'b0, resp_rw;
   logic [7:0] resp_seq, resp_len;
   logic       busy;

   ecpri_rma_scheduler #(.ADDR_W(8), .LEN_W(8), .DEPTH(4)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
      .req_addr(req_addr), .req_len(req_len), .req_seq(req_seq),
      .wr_data_valid(wr_data_valid), .wr_data(wr_data), .wr_data_ready(wr_data_ready),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .rd_data_valid(rd_data_valid), .rd_data(rd_data), .rd_data_ready(rd_data_ready),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rw(resp_rw),
      .resp_seq(resp_seq), .resp_len(resp_len), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rw;
      logic [7:0] addr;
      logic [7:0] len;
      logic [7:0] seq;
   } req_t;

   logic [7:0]  ram     [256];
   logic [7:0]  ref_mem [256];
   req_t        exp_q[$];
   logic [7:0]  wr_q[$];
   logic [7:0]  next_bytes[$];
   logic [7:0]  rd_seen[$];
   logic [7:0]  resp_log[$];
   int          done = 0;
   int          n_checks = 0;
   int          n_pass = 0;
   int unsigned wr_pct = 100, rd_pct = 100, resp_pct = 100;
   logic        hold_v = 1'b0;
   logic [7:0]  hold_d = '0;
   logic [7:0]  mon_a;
   req_t        mon_r;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   function automatic logic front_ok(input logic rw);
      return exp_q.size() != 0 && exp_q[0].rw == rw && done < int'(exp_q[0].len);
   endfunction

   // Attached single-port RAM: registered read, data valid the cycle after the strobe.
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) ram[mem_addr] <= mem_wdata;
         else        mem_rdata     <= ram[mem_addr];
      end
   end

   // Stimulus sources for the byte streams and back-pressure.
   always @(posedge clk) begin
      #1;
      wr_data_valid = (wr_q.size() != 0) && ($urandom_range(99) < wr_pct);
      wr_data       = (wr_q.size() != 0) ? wr_q[0] : 8'h00;
      rd_data_ready = $urandom_range(99) < rd_pct;
      resp_ready    = $urandom_range(99) < resp_pct;
   end

   // Reference model: each request runs to completion in submission order.
   always @(negedge clk) begin
      if (!reset) begin
         if (wr_data_valid && wr_data_ready) begin
            if (!front_ok(1'b1)) check("wr_unexpected", 1, 0);
            else begin
               mon_a = exp_q[0].addr + 8'(done);
               check("wr_strobe", {mem_en, mem_we}, 2'b11);
               check("wr_addr", mem_addr, mon_a);
               check("wr_data", mem_wdata, wr_q[0]);
               ref_mem[mon_a] = wr_q[0];
               done++;
            end
            void'(wr_q.pop_front());
         end else if (mem_en && mem_we) check("wr_spurious", 1, 0);

         if (mem_en && !mem_we) begin
            if (!front_ok(1'b0)) check("rd_spurious", 1, 0);
            else check("rd_addr", mem_addr, exp_q[0].addr + 8'(done));
         end

         if (rd_data_valid) begin
            if (hold_v) check("rd_hold", rd_data, hold_d);
            hold_v = !rd_data_ready;
            hold_d = rd_data;
         end else hold_v = 1'b0;

         if (rd_data_valid && rd_data_ready) begin
            if (!front_ok(1'b0)) check("rd_unexpected", 1, 0);
            else begin
               check("rd_data", rd_data, ref_mem[exp_q[0].addr + 8'(done)]);
               rd_seen.push_back(rd_data);
               done++;
            end
         end

         if (resp_valid && resp_ready) begin
            if (exp_q.size() == 0) check("resp_unexpected", 1, 0);
            else begin
               check("resp_fields", {resp_rw, resp_seq, resp_len},
                     {exp_q[0].rw, exp_q[0].seq, exp_q[0].len});
               check("resp_done", done, int'(exp_q[0].len));
               resp_log.push_back(resp_seq);
               void'(exp_q.pop_front());
               done = 0;
            end
         end

         if (req_valid && req_ready) begin
            mon_r.rw = req_rw; mon_r.addr = req_addr; mon_r.len = req_len; mon_r.seq = req_seq;
            exp_q.push_back(mon_r);
         end
      end
   end

   // Offer one request until accepted; bytes for writes join the payload stream on acceptance.
   task automatic submit(input logic rw, input logic [7:0] addr, input logic [7:0] len,
                         input logic [7:0] seq);
      int  t = 0;
      bit  got = 0;
      req_valid = 1'b1; req_rw = rw; req_addr = addr; req_len = len; req_seq = seq;
      while (!got && t < 500) begin
         @(negedge clk);
         if (req_ready) begin
            got = 1;
            if (rw) for (int i = 0; i < int'(len); i++)
               wr_q.push_back(next_bytes.size() != 0 ? next_bytes.pop_front() : 8'($urandom));
         end
         t++;
         @(posedge clk); #1;
      end
      req_valid = 1'b0;
      check("accept", got, 1);
   endtask

   task automatic drain();
      int t = 0;
      while ((exp_q.size() != 0 || busy) && t < 3000) begin
         @(posedge clk); #1;
         t++;
      end
      check("drain", (exp_q.size() == 0) && !busy, 1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check(tag, {req_ready, wr_data_ready, mem_en, mem_we, mem_addr, mem_wdata, rd_data_valid,
                  rd_data, resp_valid, resp_rw, resp_seq, resp_len, busy}, 64'h0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int         base;
      int         t;
      logic [5:0] rdy;

      for (int i = 0; i < 256; i++) begin
         ram[i]     = 8'($urandom);
         ref_mem[i] = ram[i];
      end
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset_outputs");
      reset = 1'b0;
      #1;
      check("ready_after_reset", req_ready, 1);
      @(posedge clk); #1;

      // Four-byte write.
      next_bytes = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
      base = resp_log.size();
      submit(1'b1, 8'h10, 8'd4, 8'h05);
      drain();
      check("t1_mem", {ram[8'h10], ram[8'h11], ram[8'h12], ram[8'h13]}, 32'hAABBCCDD);
      check("t1_resp_count", resp_log.size() - base, 1);

      // Read with a toggling consumer.
      ram[8'h20] = 8'h11; ram[8'h21] = 8'h22; ram[8'h22] = 8'h33;
      ref_mem[8'h20] = 8'h11; ref_mem[8'h21] = 8'h22; ref_mem[8'h22] = 8'h33;
      rd_pct = 50;
      base = rd_seen.size();
      submit(1'b0, 8'h20, 8'd3, 8'h21);
      drain();
      check("t2_count", rd_seen.size() - base, 3);
      if (rd_seen.size() - base == 3)
         check("t2_bytes", {rd_seen[base], rd_seen[base+1], rd_seen[base+2]}, 24'h112233);

      // Back-to-back offers against a stalled reader.
      rd_pct = 0; rd_data_ready = 1'b0;
      base = resp_log.size();
      for (int i = 0; i < 6; i++) begin
         req_valid = 1'b1; req_rw = 1'b0; req_addr = 8'(8'h40 + 4 * i);
         req_len = 8'd2; req_seq = 8'(8'h30 + i);
         @(negedge clk);
         rdy[i] = req_ready;
         @(posedge clk); #1;
      end
      req_valid = 1'b0;
      check("t3_ready", rdy, 6'b011111);
      rd_pct = 70;
      submit(1'b0, 8'h54, 8'd2, 8'h35);
      drain();
      check("t3_resp_count", resp_log.size() - base, 6);
      if (resp_log.size() - base == 6)
         for (int i = 0; i < 6; i++) check("t3_order", resp_log[base+i], 8'(8'h30 + i));

      // Write wrapping past the top of the address space.
      next_bytes = '{8'h01, 8'h02, 8'h03};
      submit(1'b1, 8'hFE, 8'd3, 8'h44);
      drain();
      check("t4_mem", {ram[8'hFE], ram[8'hFF], ram[8'h00]}, 24'h010203);

      // Zero-length read: straight to the response, no memory access.
      resp_pct = 100; resp_ready = 1'b1;
      submit(1'b0, 8'h55, 8'd0, 8'h7F);
      @(negedge clk);
      check("t5_idle_cycle", resp_valid, 0);
      @(negedge clk);
      check("t5_resp", {resp_valid, resp_rw, resp_seq, resp_len}, {1'b1, 1'b0, 8'h7F, 8'h00});
      drain();

      // Reset mid-write with two requests queued behind it.
      wr_pct = 0; wr_data_valid = 1'b0;
      submit(1'b1, 8'h80, 8'd4, 8'h60);
      submit(1'b0, 8'h90, 8'd2, 8'h61);
      submit(1'b1, 8'hA0, 8'd1, 8'h62);
      wr_pct = 100;
      t = 0;
      while (done < 2 && t < 100) begin @(negedge clk); t++; end
      check("t6_two_bytes", done, 2);
      @(posedge clk); #2;
      reset = 1'b1;
      exp_q.delete(); wr_q.delete(); done = 0; hold_v = 1'b0;
      #1;
      check_reset_outputs("t6_reset_outputs");
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      check("t6_ready", {req_ready, busy}, 2'b10);
      base = resp_log.size();
      repeat (10) @(negedge clk);
      check("t6_no_resp", resp_log.size() - base, 0);
      @(posedge clk); #1;
      submit(1'b1, 8'h80, 8'd4, 8'h63);
      drain();
      check("t6_new_write", resp_log.size() - base, 1);

      // Randomised traffic under random back-pressure.
      wr_pct = 70; rd_pct = 70; resp_pct = 70;
      for (int k = 0; k < 40; k++) begin
         submit(1'($urandom), 8'($urandom), 8'($urandom_range(5)), 8'(k));
         repeat ($urandom_range(3)) begin @(posedge clk); #1; end
      end
      drain();

      t = 0;
      for (int i = 0; i < 256; i++) if (ram[i] !== ref_mem[i]) t++;
      check("mem_final", t, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
